// File: rtl/arbitro_registrador_n_pkg.sv
// rtl/arbitro_registrador_n_pkg.sv - shared state encodings for the register arbiter
package arbitro_registrador_n_pkg;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ESCREVE  = 3'd1,
        CONFIRMA = 3'd2,
        LIBERA   = 3'd3,
        LIMPA    = 3'd4
    } estado_t;

endpackage

// File: rtl/arbitro_registrador_n_rr_prioridade.sv
// rtl/arbitro_registrador_n_rr_prioridade.sv - combinational round-robin winner select
module rr_prioridade
    import arbitro_registrador_n_pkg::*;
#(
    parameter int K     = 4,
    parameter int IDX_W = 2
) (
    input  logic [K-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the far end so the closest requester to ptr is written last and wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int off = K - 1; off >= 0; off--) begin
            if (req[(int'(ptr) + off) % K]) begin
                valid = 1'b1;
                idx   = IDX_W'((int'(ptr) + off) % K);
            end
        end
    end

endmodule

// File: rtl/registrador_n.sv
// rtl/registrador_n.sv - N-bit register with synchronous clear and load enable
module registrador_n #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         enable,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clock) begin
        if (clear) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/arbitro_registrador_n.sv
// rtl/arbitro_registrador_n.sv - round-robin write arbiter in front of one shared registrador_n
module arbitro_registrador_n
    import arbitro_registrador_n_pkg::*;
#(
    parameter int N     = 32,
    parameter int K     = 4,
    parameter int CNT_W = 8,
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic [K-1:0]     req,
    input  logic [K*N-1:0]   data_in,
    input  logic             limpa,
    output logic [K-1:0]     ack,
    output logic             reg_enable,
    output logic             reg_clear,
    output logic [N-1:0]     reg_D,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic [CNT_W-1:0] write_count
);

    estado_t          state;
    logic [IDX_W-1:0] ptr;
    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] next_ptr;
    logic [N-1:0]     win_data;

    rr_prioridade #(.K(K), .IDX_W(IDX_W)) u_rr (
        .req   (req),
        .ptr   (ptr),
        .valid (win_valid),
        .idx   (win_idx)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < K; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_data = data_in[i*N +: N];
            end
        end
    end

    assign next_ptr = (win_idx == IDX_W'(K - 1)) ? '0 : win_idx + 1'b1;
    assign busy     = (state != OCIOSO);

    // reg_D doubles as the latched write data, so it holds outside ESCREVE.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state       <= OCIOSO;
            ptr         <= '0;
            ack         <= '0;
            reg_enable  <= 1'b0;
            reg_clear   <= 1'b0;
            reg_D       <= '0;
            grant_idx   <= '0;
            write_count <= '0;
        end else begin
            ack        <= '0;
            reg_enable <= 1'b0;
            reg_clear  <= 1'b0;
            case (state)
                OCIOSO: begin
                    if (limpa) begin
                        state     <= LIMPA;
                        reg_clear <= 1'b1;
                    end else if (win_valid) begin
                        state      <= ESCREVE;
                        reg_enable <= 1'b1;
                        reg_D      <= win_data;
                        grant_idx  <= win_idx;
                        ptr        <= next_ptr;
                    end
                end
                ESCREVE: begin
                    state       <= CONFIRMA;
                    ack         <= K'(1) << grant_idx;
                    write_count <= write_count + 1'b1;
                end
                CONFIRMA: state <= LIBERA;
                // Wait for the owner to drop its level so one request never writes twice.
                LIBERA: begin
                    if (!req[grant_idx]) begin
                        state <= OCIOSO;
                    end
                end
                LIMPA:   state <= OCIOSO;
                default: state <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_registrador_n.sv
// tb/tb_arbitro_registrador_n.sv - self-checking bench for arbitro_registrador_n with registrador_n
module tb_arbitro_registrador_n;

    localparam int N     = 32;
    localparam int K     = 4;
    localparam int CNT_W = 8;
    localparam int IDX_W = 2;

    logic             clock;
    logic             clear_n;
    logic [K-1:0]     req;
    logic [K*N-1:0]   data_in;
    logic             limpa;
    logic [K-1:0]     ack;
    logic             reg_enable;
    logic             reg_clear;
    logic [N-1:0]     reg_d;
    logic [IDX_W-1:0] grant_idx;
    logic             busy;
    logic [CNT_W-1:0] write_count;
    logic [N-1:0]     q;

    int errors = 0;
    int checks = 0;

    arbitro_registrador_n #(.N(N), .K(K), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .req         (req),
        .data_in     (data_in),
        .limpa       (limpa),
        .ack         (ack),
        .reg_enable  (reg_enable),
        .reg_clear   (reg_clear),
        .reg_D       (reg_d),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .write_count (write_count)
    );

    registrador_n #(.N(N)) u_reg (
        .clock  (clock),
        .clear  (reg_clear),
        .enable (reg_enable),
        .d      (reg_d),
        .q      (q)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        req     = '0;
        limpa   = 1'b0;
        @(negedge clock);
        @(negedge clock);
        clear_n = 1'b1;
    endtask

    task automatic do_write(input int who, input logic [N-1:0] d, input logic [N-1:0] d2,
                            input int hold, input logic [N-1:0] exp_q, input int exp_cnt);
        int t;
        int bad;
        data_in[who*N +: N] = d;
        req[who] = 1'b1;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!reg_enable && t < 10);
        check("wr_enable", reg_enable, 1);
        check("wr_D", reg_d, exp_q);
        check("wr_idx", grant_idx, who);
        data_in[who*N +: N] = d2;
        @(negedge clock);
        check("wr_ack", ack, 64'd1 << who);
        check("wr_Q", q, exp_q);
        check("wr_count", write_count, exp_cnt);
        bad = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            if (reg_enable || ack != 0 || !busy) bad++;
        end
        if (hold > 0) check("wr_hold_no_rewrite", bad, 0);
        req[who] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("wr_back_idle", busy, 0);
    endtask

    typedef struct {
        int           who;
        logic [N-1:0] d;
        logic [N-1:0] d2;
        int           hold;
        logic [N-1:0] exp_q;
    } wr_vec_t;

    typedef struct {
        int           idx;
        logic [N-1:0] q;
    } cont_vec_t;

    wr_vec_t   wv[4];
    cont_vec_t cv[5];

    initial begin
        int t, bad, n, w, cur, model_ptr, exp_cnt, timeouts;
        logic ack_due;
        logic [N-1:0] q0, cur_data;
        int down[K];
        int st[K], gap[K], hold[K], waitc[K], maxw[K], served[K];

        wv[0] = '{1, 32'd5,          32'd5,  3, 32'd5};
        wv[1] = '{0, 32'd53,         32'd99, 0, 32'd53};
        wv[2] = '{3, 32'hFFFF_FFFF,  32'd0,  1, 32'hFFFF_FFFF};
        wv[3] = '{2, 32'd0,          32'd7,  0, 32'd0};
        cv[0] = '{0, 32'd11};
        cv[1] = '{1, 32'd22};
        cv[2] = '{2, 32'd33};
        cv[3] = '{3, 32'd44};
        cv[4] = '{0, 32'd11};

        clear_n = 1'b1;
        req     = '0;
        limpa   = 1'b0;
        data_in = '0;

        // reset and idle
        @(negedge clock);
        clear_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_ack", ack, 0);
        check("rst_enable", reg_enable, 0);
        check("rst_clear", reg_clear, 0);
        check("rst_D", reg_d, 0);
        check("rst_idx", grant_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_count", write_count, 0);
        clear_n = 1'b1;
        q0 = q;
        bad = 0;
        repeat (10) begin
            @(negedge clock);
            if (busy || reg_enable || reg_clear || ack != 0) bad++;
        end
        check("idle_quiet", bad, 0);
        check("idle_Q", q, q0);

        // single writes from a table, including data change after grant and held req
        for (int v = 0; v < 4; v++) begin
            do_write(wv[v].who, wv[v].d, wv[v].d2, wv[v].hold, wv[v].exp_q, v + 1);
        end

        // contention, all four requesting
        do_reset();
        for (int i = 0; i < K; i++) begin
            data_in[i*N +: N] = 32'(11 * (i + 1));
            down[i] = 0;
        end
        req = '1;
        n = 0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            @(negedge clock);
            for (int i = 0; i < K; i++) begin
                if (down[i] > 0) begin
                    down[i]--;
                    if (down[i] == 0) req[i] = 1'b1;
                end
            end
            if (ack != 0) begin
                check("cont_ack", ack, 64'd1 << cv[n].idx);
                check("cont_Q", q, cv[n].q);
                n++;
                for (int i = 0; i < K; i++) begin
                    if (ack[i]) begin
                        req[i]  = 1'b0;
                        down[i] = 2;
                    end
                end
            end
        end
        check("cont_grants", n, 5);
        check("cont_count", write_count, 5);
        req = '0;
        repeat (3) @(negedge clock);

        // clear has priority over a simultaneous request
        limpa = 1'b1;
        req[2] = 1'b1;
        data_in[2*N +: N] = 32'd111;
        @(negedge clock);
        check("clr_pulse", reg_clear, 1);
        check("clr_no_enable", reg_enable, 0);
        limpa = 1'b0;
        @(negedge clock);
        check("clr_Q_zero", q, 0);
        check("clr_count_kept", write_count, 5);
        @(negedge clock);
        check("clr_then_grant", grant_idx, 2);
        check("clr_then_enable", reg_enable, 1);
        @(negedge clock);
        check("clr_then_ack", ack, 4'b0100);
        check("clr_then_Q", q, 111);
        req = '0;
        repeat (3) @(negedge clock);

        // asynchronous reset in the middle of a write
        q0 = q;
        req[3] = 1'b1;
        data_in[3*N +: N] = 32'd77;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!reg_enable && t < 10);
        check("abort_reached_write", reg_enable, 1);
        #2 clear_n = 1'b0;
        #1;
        check("abort_async_enable", reg_enable, 0);
        check("abort_async_busy", busy, 0);
        req = '0;
        @(negedge clock);
        @(negedge clock);
        clear_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clock);
            if (ack != 0) bad++;
        end
        check("abort_no_ack", bad, 0);
        check("abort_count", write_count, 0);
        check("abort_Q", q, q0);

        // counter wrap
        do_reset();
        timeouts = 0;
        for (int k = 0; k < 256; k++) begin
            req[0] = 1'b1;
            data_in[N-1:0] = 32'(k);
            t = 0;
            do begin
                @(negedge clock);
                t++;
            end while (!ack[0] && t < 10);
            if (t >= 10) timeouts++;
            req[0] = 1'b0;
            if (k == 254) check("wrap_255", write_count, 255);
            @(negedge clock);
            @(negedge clock);
        end
        check("wrap_timeouts", timeouts, 0);
        check("wrap_zero", write_count, 0);

        // randomized traffic against a transaction-level round-robin model
        do_reset();
        model_ptr = 0;
        exp_cnt   = 0;
        ack_due   = 1'b0;
        cur       = 0;
        cur_data  = '0;
        for (int i = 0; i < K; i++) begin
            st[i] = 0; gap[i] = 1; hold[i] = 0; waitc[i] = 0; maxw[i] = 0; served[i] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            check("rnd_exclusive",
                  (int'(ack != 0) + int'(reg_enable) + int'(reg_clear)) <= 1, 1);
            if (ack_due) begin
                check("rnd_ack", ack, 64'd1 << cur);
                check("rnd_Q", q, cur_data);
                check("rnd_count", write_count, exp_cnt % 256);
                ack_due = 1'b0;
            end else begin
                check("rnd_no_ack", ack, 0);
            end
            if (reg_enable) begin
                w = -1;
                for (int o = 0; o < K; o++) begin
                    if (req[(model_ptr + o) % K]) begin
                        w = (model_ptr + o) % K;
                        break;
                    end
                end
                check("rnd_grant_expected", w >= 0, 1);
                if (w >= 0) begin
                    check("rnd_idx", grant_idx, w);
                    check("rnd_D", reg_d, data_in[w*N +: N]);
                    cur       = w;
                    cur_data  = data_in[w*N +: N];
                    model_ptr = (w + 1) % K;
                    exp_cnt++;
                    ack_due   = 1'b1;
                end
            end
            for (int i = 0; i < K; i++) begin
                case (st[i])
                    0: begin
                        if (gap[i] > 0) gap[i]--;
                        else if ($urandom_range(0, 2) == 0) begin
                            req[i] = 1'b1;
                            data_in[i*N +: N] = $urandom;
                            st[i] = 1;
                            waitc[i] = 0;
                        end
                    end
                    1: begin
                        if (ack[i]) begin
                            served[i]++;
                            hold[i] = $urandom_range(0, 2);
                            st[i] = 2;
                        end else begin
                            waitc[i]++;
                            if (waitc[i] > maxw[i]) maxw[i] = waitc[i];
                        end
                    end
                    default: ;
                endcase
                if (st[i] == 2) begin
                    if (hold[i] == 0) begin
                        req[i] = 1'b0;
                        st[i]  = 0;
                        gap[i] = 2 + $urandom_range(0, 3);
                    end else begin
                        hold[i]--;
                    end
                end
                if ($urandom_range(0, 3) == 0) data_in[i*N +: N] = $urandom;
            end
        end
        for (int i = 0; i < K; i++) begin
            check("rnd_wait_bound", maxw[i] <= 40, 1);
            check("rnd_served", served[i] > 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
